sw_input_ctrl: RTL

- Bus-slave input peripheral for lt16soc: the read direction complementing the LED output port.
- Samples NUM_IN external switch/button pins, synchronises and debounces them, and latches per-bit edge events.
- Exposes debounced state, sticky edge status, and interrupt controls over a single-cycle Wishbone-classic slave port.
- Drives a level interrupt toward the core.

---
 rtl/sw_input_pkg.sv | 25 ++
 rtl/sw_debounce.sv | 46 ++++
 rtl/sw_input_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sw_input_pkg.sv
// sw_input_pkg: shared definitions for the sw_input_ctrl switch/button
// input peripheral.
//   - byte offsets of the four registers on the Wishbone slave port
//   - 2-bit register index type (byte address bits [3:2])
//   - bus handshake state type
package sw_input_pkg;

    localparam logic [3:0] SW_DATA_OFS    = 4'h0;
    localparam logic [3:0] SW_STATUS_OFS  = 4'h4;
    localparam logic [3:0] SW_IRQEN_OFS   = 4'h8;
    localparam logic [3:0] SW_EDGESEL_OFS = 4'hC;

    typedef logic [1:0] reg_idx_t;

    localparam reg_idx_t SW_DATA_IDX    = SW_DATA_OFS[3:2];
    localparam reg_idx_t SW_STATUS_IDX  = SW_STATUS_OFS[3:2];
    localparam reg_idx_t SW_IRQEN_IDX   = SW_IRQEN_OFS[3:2];
    localparam reg_idx_t SW_EDGESEL_IDX = SW_EDGESEL_OFS[3:2];

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_t;

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: one input pin -> 2-flop synchroniser -> debounced level.
//   clk_sys  in   system clock
//   rst      in   asynchronous active-low reset
//   pin      in   raw asynchronous pin
//   stable   out  debounced level; follows the synchronised pin only after
//                 it has differed from stable for DEBOUNCE_CYCLES cycles
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic pin,
    output logic stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_sys or negedge rst) begin
        if (!rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            if (sync2 != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                // any return to the stable level restarts the count
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sw_input_ctrl.sv
// sw_input_ctrl: switch/button input peripheral for lt16soc.
// Debounces NUM_IN pins, latches per-bit edge events into a sticky STATUS
// register and raises a level interrupt for enabled events.
//   clk_sys   in   system clock
//   rst       in   asynchronous active-low reset
//   sw_in     in   raw pin inputs [NUM_IN]
//   wb_cyc/wb_stb/wb_we/wb_adr/wb_sel/wb_dat_i  Wishbone-classic slave inputs
//   wb_dat_o  out  read data, captured on the transfer edge
//   wb_ack    out  one-cycle acknowledge
//   irq       out  |(STATUS & IRQ_EN), registered
// Registers: 0x0 DATA (RO), 0x4 STATUS (W1C), 0x8 IRQ_EN (RW),
//            0xC EDGE_SEL (RW, 0 = rising, 1 = falling).
module sw_input_ctrl
    import sw_input_pkg::*;
#(
    parameter int NUM_IN          = 8,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic [NUM_IN-1:0] sw_in,
    input  logic              wb_cyc,
    input  logic              wb_stb,
    input  logic              wb_we,
    input  logic [3:0]        wb_adr,
    input  logic [3:0]        wb_sel,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack,
    output logic              irq
);

    logic [NUM_IN-1:0] stable;
    logic [NUM_IN-1:0] stable_q;
    logic [NUM_IN-1:0] status;
    logic [NUM_IN-1:0] irq_en;
    logic [NUM_IN-1:0] edge_sel;
    logic [NUM_IN-1:0] evt;

    bus_state_t state;
    bus_state_t state_nxt;
    logic       xfer;

    reg_idx_t          ridx;
    logic [31:0]       wmask;
    logic [31:0]       wr_val;
    logic [NUM_IN-1:0] wr_bits;
    logic [NUM_IN-1:0] keep_bits;
    logic [NUM_IN-1:0] clr;
    logic [31:0]       rdata;
    logic              unused_bits;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_db
        sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk_sys(clk_sys),
            .rst    (rst),
            .pin    (sw_in[g]),
            .stable (stable[g])
        );
    end

    // rising when edge_sel=0, falling when edge_sel=1
    assign evt = (~edge_sel & stable & ~stable_q) | (edge_sel & ~stable & stable_q);

    // ---------------- bus handshake ----------------
    always_comb begin
        state_nxt = state;
        xfer      = 1'b0;
        case (state)
            BUS_IDLE: begin
                if (wb_cyc && wb_stb) begin
                    xfer      = 1'b1;
                    state_nxt = BUS_ACK;
                end
            end
            BUS_ACK:  state_nxt = BUS_IDLE;
            default:  state_nxt = BUS_IDLE;
        endcase
    end

    assign wb_ack = (state == BUS_ACK);

    // ---------------- write path ----------------
    assign ridx = wb_adr[3:2];

    always_comb begin
        wmask = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            wmask[8*i +: 8] = {8{wb_sel[i]}};
        end
    end

    assign wr_val    = wb_dat_i & wmask;
    assign wr_bits   = wr_val[NUM_IN-1:0];
    assign keep_bits = ~wmask[NUM_IN-1:0];
    assign clr       = (xfer && wb_we && ridx == SW_STATUS_IDX) ? wr_bits : '0;

    // ---------------- read path ----------------
    always_comb begin
        rdata = '0;
        case (ridx)
            SW_DATA_IDX:    rdata = 32'(stable);
            SW_STATUS_IDX:  rdata = 32'(status);
            SW_IRQEN_IDX:   rdata = 32'(irq_en);
            SW_EDGESEL_IDX: rdata = 32'(edge_sel);
            default:        rdata = '0;
        endcase
    end

    assign unused_bits = ^{wb_adr[1:0], wr_val};

    always_ff @(posedge clk_sys or negedge rst) begin
        if (!rst) begin
            state    <= BUS_IDLE;
            stable_q <= '0;
            status   <= '0;
            irq_en   <= '0;
            edge_sel <= '0;
            wb_dat_o <= '0;
            irq      <= 1'b0;
        end else begin
            state    <= state_nxt;
            stable_q <= stable;
            // a new event outranks a simultaneous W1C of the same bit
            status   <= (status & ~clr) | evt;
            irq      <= |(status & irq_en);
            if (xfer && !wb_we) begin
                wb_dat_o <= rdata;
            end
            if (xfer && wb_we) begin
                if (ridx == SW_IRQEN_IDX) begin
                    irq_en <= (irq_en & keep_bits) | wr_bits;
                end
                if (ridx == SW_EDGESEL_IDX) begin
                    edge_sel <= (edge_sel & keep_bits) | wr_bits;
                end
            end
        end
    end

endmodule
